// File: rtl/menu_ctrl_pkg.sv
// Shared types and constants for the on-screen menu controller.
package menu_pkg;

    // Character codes understood by the overlay character ROM.
    localparam logic [3:0] CHAR_B     = 4'd10;
    localparam logic [3:0] CHAR_F     = 4'd11;
    localparam logic [3:0] CHAR_I     = 4'd12;
    localparam logic [3:0] CHAR_U     = 4'd13;
    localparam logic [3:0] CHAR_Z     = 4'd14;
    localparam logic [3:0] CHAR_BLANK = 4'd15;

    // Label line per menu entry, char 0 in [3:0].
    // Entry 0 reads "FIZZBUZZ"; entries 1..15 read "BUZZ" blank, two decimal digits, blank.
    localparam logic [31:0] LABEL [16] = '{
        32'hEEDAEECB, 32'hF10FEEDA, 32'hF20FEEDA, 32'hF30FEEDA,
        32'hF40FEEDA, 32'hF50FEEDA, 32'hF60FEEDA, 32'hF70FEEDA,
        32'hF80FEEDA, 32'hF90FEEDA, 32'hF01FEEDA, 32'hF11FEEDA,
        32'hF21FEEDA, 32'hF31FEEDA, 32'hF41FEEDA, 32'hF51FEEDA
    };

    // Button indices into the debounced vectors; lower index wins on simultaneous presses.
    localparam int BTN_UP   = 0;
    localparam int BTN_DOWN = 1;
    localparam int BTN_INC  = 2;
    localparam int BTN_DEC  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

endpackage

// File: rtl/menu_ctrl_if.sv
// Button/frame inputs and overlay outputs of the menu controller.
interface menu_ctrl_if #(
    parameter int N_ITEMS = 4
) ();
    localparam int SEL_W = $clog2(N_ITEMS);

    logic               btn_up;
    logic               btn_down;
    logic               btn_inc;
    logic               btn_dec;
    logic               newframe;
    logic [31:0]        line;
    logic [5:0]         value;
    logic [SEL_W-1:0]   sel;

    modport master (
        output btn_up, btn_down, btn_inc, btn_dec, newframe,
        input  line, value, sel
    );

    modport slave (
        input  btn_up, btn_down, btn_inc, btn_dec, newframe,
        output line, value, sel
    );
endinterface

// File: rtl/menu_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, rising-edge press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          r_s1, r_s2;
    logic [1:0]    r_vld;
    logic          r_armed;
    logic [CW-1:0] r_cnt;
    logic          r_level, r_level_q;
    logic          r_press;

    // Sync, count disagreement, accept new level, and pulse on accepted rising edges.
    // A button must be seen low after reset (armed) before its rises generate presses,
    // so a button held through reset stays silent until released and pressed again.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_vld     <= '0;
            r_armed   <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_s1      <= raw;
            r_s2      <= r_s1;
            r_vld     <= {r_vld[0], 1'b1};
            if (r_vld[1] && !r_s2)
                r_armed <= 1'b1;
            if (r_s2 == r_level)
                r_cnt <= '0;
            else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else
                r_cnt <= r_cnt + 1'b1;
            r_level_q <= r_level;
            r_press   <= r_level & ~r_level_q & r_armed;
        end
    end

    assign level = r_level;
    assign press = r_press;
endmodule

// File: rtl/menu_ctrl.sv
// Menu cursor/value controller with auto-repeat; outputs are frame-synchronous shadows.
module menu_ctrl
    import menu_pkg::*;
#(
    parameter int N_ITEMS         = 4,
    parameter int DEBOUNCE_CYC    = 250000,
    parameter int REPEAT_FIRST_FR = 30,
    parameter int REPEAT_NEXT_FR  = 6
) (
    input  logic        clk,
    input  logic        rst,
    menu_ctrl_if.slave  if_menu
);
    localparam int SEL_W = $clog2(N_ITEMS);
    localparam int FMAX  = (REPEAT_FIRST_FR > REPEAT_NEXT_FR) ? REPEAT_FIRST_FR : REPEAT_NEXT_FR;
    localparam int FCW   = $clog2(FMAX + 1);

    logic [3:0] w_raw, w_level, w_press;

    assign w_raw = {if_menu.btn_dec, if_menu.btn_inc, if_menu.btn_down, if_menu.btn_up};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (w_raw[g]),
            .level (w_level[g]),
            .press (w_press[g])
        );
    end

    state_t         r_state, w_state_nx;
    logic [1:0]     r_own, w_own_nx;     // button that owns HOLD/REPEAT
    logic [FCW-1:0] r_fcnt, w_fcnt_nx;   // frames since last step
    logic [FCW-1:0] w_lim_m1;
    logic [3:0]     w_act;               // one-hot action this cycle

    logic [SEL_W-1:0] r_sel_w;
    logic [5:0]       r_val_w [N_ITEMS];
    logic [SEL_W-1:0] r_sel;
    logic [5:0]       r_value;
    logic [31:0]      r_line;

    assign w_lim_m1 = (r_state == ST_HOLD) ? FCW'(REPEAT_FIRST_FR - 1) : FCW'(REPEAT_NEXT_FR - 1);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_own   <= 2'(BTN_INC);
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_own   <= w_own_nx;
            r_fcnt  <= w_fcnt_nx;
        end
    end

    // Next state and action select: priority press decode in IDLE, frame-paced repeat otherwise.
    always_comb begin
        w_state_nx = r_state;
        w_own_nx   = r_own;
        w_fcnt_nx  = r_fcnt;
        w_act      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_press[BTN_UP])
                    w_act[BTN_UP] = 1'b1;
                else if (w_press[BTN_DOWN])
                    w_act[BTN_DOWN] = 1'b1;
                else if (w_press[BTN_INC] || w_press[BTN_DEC]) begin
                    w_own_nx   = w_press[BTN_INC] ? 2'(BTN_INC) : 2'(BTN_DEC);
                    w_act[w_own_nx] = 1'b1;
                    w_state_nx = ST_HOLD;
                    w_fcnt_nx  = '0;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (!w_level[r_own]) begin
                    w_state_nx = ST_IDLE;
                    w_fcnt_nx  = '0;
                end else if (if_menu.newframe) begin
                    if (r_fcnt == w_lim_m1) begin
                        w_act[r_own] = 1'b1;
                        w_fcnt_nx    = '0;
                        w_state_nx   = ST_REPEAT;
                    end else
                        w_fcnt_nx = r_fcnt + 1'b1;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Working registers and frame-synchronous output shadows (shadows take pre-action values).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_w <= '0;
            for (int i = 0; i < N_ITEMS; i++)
                r_val_w[i] <= '0;
            r_sel   <= '0;
            r_value <= '0;
            r_line  <= LABEL[0];
        end else begin
            if (w_act[BTN_UP])
                r_sel_w <= (r_sel_w == '0) ? SEL_W'(N_ITEMS - 1) : r_sel_w - 1'b1;
            if (w_act[BTN_DOWN])
                r_sel_w <= (r_sel_w == SEL_W'(N_ITEMS - 1)) ? '0 : r_sel_w + 1'b1;
            if (w_act[BTN_INC] && r_val_w[r_sel_w] != 6'd63)
                r_val_w[r_sel_w] <= r_val_w[r_sel_w] + 6'd1;
            if (w_act[BTN_DEC] && r_val_w[r_sel_w] != 6'd0)
                r_val_w[r_sel_w] <= r_val_w[r_sel_w] - 6'd1;
            if (if_menu.newframe) begin
                r_sel   <= r_sel_w;
                r_value <= r_val_w[r_sel_w];
                r_line  <= LABEL[4'(r_sel_w)];
            end
        end
    end

    assign if_menu.sel   = r_sel;
    assign if_menu.value = r_value;
    assign if_menu.line  = r_line;
endmodule

// File: tb/tb_menu_ctrl.sv
// Randomized self-checking bench for menu_ctrl against an action-level menu model.
module tb_menu_ctrl;
    localparam int N  = 4;
    localparam int DB = 4;
    localparam int RF = 3;
    localparam int RN = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    menu_ctrl_if #(.N_ITEMS(N)) bus ();

    menu_ctrl #(
        .N_ITEMS(N), .DEBOUNCE_CYC(DB), .REPEAT_FIRST_FR(RF), .REPEAT_NEXT_FR(RN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .if_menu (bus)
    );

    int errs = 0;
    int checks = 0;

    // Model: working cursor/values, held-button frame count, and displayed shadow.
    int m_sel;
    int m_val [N];
    int m_hold;   // -1 none, 2 inc, 3 dec
    int m_hfr;
    int s_sel, s_val;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_line(input int s);
        logic [3:0] c [8];
        logic [31:0] l;
        if (s == 0) c = '{4'd11, 4'd12, 4'd14, 4'd14, 4'd10, 4'd13, 4'd14, 4'd14};
        else        c = '{4'd10, 4'd13, 4'd14, 4'd14, 4'd15, 4'(s / 10), 4'(s % 10), 4'd15};
        l = '0;
        for (int i = 0; i < 8; i++) l[i*4 +: 4] = c[i];
        return l;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: bus.btn_up   = v;
            1: bus.btn_down = v;
            2: bus.btn_inc  = v;
            default: bus.btn_dec = v;
        endcase
    endtask

    task automatic m_act(input int b);
        case (b)
            0: m_sel = (m_sel + N - 1) % N;
            1: m_sel = (m_sel + 1) % N;
            2: if (m_val[m_sel] < 63) m_val[m_sel]++;
            default: if (m_val[m_sel] > 0) m_val[m_sel]--;
        endcase
    endtask

    task automatic m_reset();
        m_sel = 0; s_sel = 0; s_val = 0; m_hold = -1; m_hfr = 0;
        for (int i = 0; i < N; i++) m_val[i] = 0;
    endtask

    task automatic chk_out(input string tag);
        chk({tag, ".sel"},   32'(bus.sel),   32'(s_sel));
        chk({tag, ".value"}, 32'(bus.value), 32'(s_val));
        chk({tag, ".line"},  bus.line,       exp_line(s_sel));
    endtask

    // One newframe pulse; the shadow takes pre-action state, then held repeat steps apply.
    task automatic frame(input string tag);
        bus.newframe = 1'b1;
        cyc(1);
        bus.newframe = 1'b0;
        s_sel = m_sel;
        s_val = m_val[m_sel];
        if (m_hold >= 0) begin
            m_hfr++;
            if (m_hfr >= RF && (m_hfr - RF) % RN == 0) m_act(m_hold);
        end
        chk_out(tag);
        cyc(18);
    endtask

    task automatic tap(input int b);
        set_btn(b, 1'b1);
        cyc(12);
        m_act(b);
        set_btn(b, 1'b0);
        cyc(12);
    endtask

    task automatic hold(input int b, input int nfr);
        set_btn(b, 1'b1);
        cyc(12);
        m_act(b);
        m_hold = b; m_hfr = 0;
        for (int i = 0; i < nfr; i++) frame("hold");
        set_btn(b, 1'b0);
        m_hold = -1;
        cyc(12);
    endtask

    task automatic combo(input int b1, input int b2);
        set_btn(b1, 1'b1);
        set_btn(b2, 1'b1);
        cyc(12);
        m_act((b1 < b2) ? b1 : b2);
        set_btn(b1, 1'b0);
        set_btn(b2, 1'b0);
        cyc(12);
    endtask

    initial begin
        rst = 1'b1;
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0;
        bus.newframe = 1'b0;
        m_reset();
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk_out("reset");
        cyc(5);
        frame("rst_frame");

        // Short glitch must not register.
        bus.btn_down = 1'b1; cyc(3); bus.btn_down = 1'b0; cyc(12);
        frame("glitch");

        tap(1);
        frame("down");
        tap(0); tap(0);
        frame("up_wrap");

        for (int i = 0; i < 70; i++) tap(2);
        frame("inc_sat");
        tap(1);
        tap(3);
        frame("dec_floor");

        hold(2, 9);
        frame("after_rel1");
        frame("after_rel2");

        combo(0, 2);
        frame("combo");

        // Press lands in the same cycle as newframe: outputs show pre-action state.
        bus.btn_down = 1'b1;
        cyc(7);
        bus.newframe = 1'b1;
        cyc(1);
        bus.newframe = 1'b0;
        s_sel = m_sel; s_val = m_val[m_sel];
        m_act(1);
        chk_out("coincide");
        bus.btn_down = 1'b0;
        cyc(12);
        frame("coincide_next");

        for (int k = 0; k < 40; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 4) tap(r);
            else if (r < 6) hold(int'($urandom_range(2, 3)), int'($urandom_range(1, 8)));
            else if (r == 6) begin
                int b1, b2;
                b1 = int'($urandom_range(0, 2));
                b2 = int'($urandom_range(b1 + 1, 3));
                combo(b1, b2);
            end else frame("rand");
        end

        // Reset during REPEAT with the inc button still held.
        bus.btn_inc = 1'b1;
        cyc(12);
        m_act(2); m_hold = 2; m_hfr = 0;
        for (int i = 0; i < 5; i++) frame("pre_rst");
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        m_reset();
        cyc(1);
        chk_out("mid_rst");
        for (int i = 0; i < 4; i++) frame("held_thru_rst");
        bus.btn_inc = 1'b0;
        cyc(12);
        tap(2);
        frame("post_rst_inc");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
